// File: rtl/tpu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : tpu_pkg
//  Description : Shared types and constants for the convolution datapath.
//  Revision    : 1.0 - initial release
// ============================================================================
package tpu_pkg;

    localparam int PKG_DATA_WIDTH      = 8;
    localparam int PKG_ACC_WIDTH       = 24;
    localparam int PKG_MAX_KERNEL_SIZE = 7;
    localparam int KERNEL_ELEMS        = PKG_MAX_KERNEL_SIZE * PKG_MAX_KERNEL_SIZE;

    typedef logic signed [PKG_DATA_WIDTH-1:0] weight_t;
    typedef logic signed [PKG_ACC_WIDTH-1:0]  acc_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        READY = 2'd2
    } conv_state_e;

endpackage
`default_nettype wire

// File: rtl/requant_clamp.sv
`default_nettype none
// ============================================================================
//  Module      : requant_clamp
//  Description : Rounding arithmetic right shift and unsigned clamp (ReLU).
//  Revision    : 1.0 - initial release
// ============================================================================
module requant_clamp
    import tpu_pkg::*;
#(
    parameter int DATA_WIDTH  = 8,
    parameter int SHIFT_WIDTH = 5
) (
    input  acc_t                   i_acc,
    input  logic [SHIFT_WIDTH-1:0] i_shift,
    output logic [DATA_WIDTH-1:0]  o_result
);

    localparam int c_acc_w = $bits(acc_t);
    localparam int c_ext_w = c_acc_w + 1;

    logic signed [c_ext_w-1:0] w_ext;
    logic signed [c_ext_w-1:0] w_half;
    logic signed [c_ext_w-1:0] w_shifted;

    // One guard bit absorbs the rounding add; shifts at or beyond the
    // accumulator width always round to zero for any representable acc.
    always_comb begin
        w_ext  = c_ext_w'(i_acc);
        w_half = '0;
        if (i_shift != '0) begin
            w_half = c_ext_w'(1) << (i_shift - SHIFT_WIDTH'(1));
        end
        w_shifted = (w_ext + w_half) >>> i_shift;
        if ((int'(i_shift) >= c_acc_w) || w_shifted[c_ext_w-1]) begin
            o_result = '0;
        end else if (|w_shifted[c_ext_w-2:DATA_WIDTH]) begin
            o_result = '1;
        end else begin
            o_result = w_shifted[DATA_WIDTH-1:0];
        end
    end

endmodule
`default_nettype wire

// File: rtl/conv_mac_unit.sv
`default_nettype none
// ============================================================================
//  Module      : conv_mac_unit
//  Description : Serially loaded kxk kernel, 4-stage dot product + bias +
//                requantisation producing one clamped pixel per window.
//  Revision    : 1.0 - initial release
// ============================================================================
module conv_mac_unit
    import tpu_pkg::*;
#(
    parameter int DATA_WIDTH        = 8,
    parameter int MAX_KERNEL_SIZE   = 7,
    parameter int KERNEL_SIZE_WIDTH = 3,
    parameter int ACC_WIDTH         = 24,
    parameter int SHIFT_WIDTH       = 5
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [KERNEL_SIZE_WIDTH-1:0] fu_kernel_size_in,
    input  logic [SHIFT_WIDTH-1:0]       fu_shift_in,
    input  logic [ACC_WIDTH-1:0]         fu_bias_in,
    input  logic                         fu_load_start_in,
    input  logic [DATA_WIDTH-1:0]        fu_weight_in,
    input  logic                         fu_weight_valid_in,
    output logic                         fu_weights_ready_out,
    input  logic [DATA_WIDTH-1:0]        fu_window_in [0:MAX_KERNEL_SIZE*MAX_KERNEL_SIZE-1],
    input  logic                         fu_window_valid_in,
    output logic [DATA_WIDTH-1:0]        fu_result_out,
    output logic [ACC_WIDTH-1:0]         fu_acc_out,
    output logic                         fu_result_valid_out,
    output logic                         fu_err_out
);

    localparam int c_elems  = MAX_KERNEL_SIZE * MAX_KERNEL_SIZE;
    localparam int c_cnt_w  = $clog2(c_elems + 1);
    localparam int c_prod_w = 2 * DATA_WIDTH + 1;

    conv_state_e                 r_state;
    conv_state_e                 w_state_next;
    logic [c_cnt_w-1:0]          r_cnt;
    logic [c_cnt_w-1:0]          r_k_sq;
    logic [SHIFT_WIDTH-1:0]      r_shift;
    logic signed [ACC_WIDTH-1:0] r_bias;
    weight_t                     r_weight [c_elems];
    logic                        r_err;
    logic                        w_ready;
    logic                        w_accept;
    logic                        w_err_set;
    logic                        w_load_last;

    logic [3:0]                  r_vld;
    logic signed [c_prod_w-1:0]  r_prod [c_elems];
    logic signed [ACC_WIDTH-1:0] r_part [MAX_KERNEL_SIZE];
    logic signed [ACC_WIDTH-1:0] w_part [MAX_KERNEL_SIZE];
    logic signed [ACC_WIDTH-1:0] w_sum;
    logic signed [ACC_WIDTH-1:0] r_bias1, r_bias2, r_acc3, r_acc4;
    logic [SHIFT_WIDTH-1:0]      r_shift1, r_shift2, r_shift3;
    logic [DATA_WIDTH-1:0]       w_result;
    logic [DATA_WIDTH-1:0]       r_result;

    assign w_load_last = (r_state == LOAD) && fu_weight_valid_in &&
                         (r_cnt == r_k_sq - c_cnt_w'(1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // A zero-size kernel has nothing to load, so it skips LOAD entirely.
    always_comb begin
        w_state_next = r_state;
        if (fu_load_start_in) begin
            w_state_next = (fu_kernel_size_in == '0) ? READY : LOAD;
        end else if (w_load_last) begin
            w_state_next = READY;
        end
    end

    always_comb begin
        w_ready   = (r_state == READY);
        w_accept  = fu_window_valid_in && w_ready;
        w_err_set = fu_window_valid_in && !w_ready;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt   <= '0;
            r_k_sq  <= '0;
            r_shift <= '0;
            r_bias  <= '0;
            r_err   <= 1'b0;
            for (int i = 0; i < c_elems; i++) r_weight[i] <= '0;
        end else if (fu_load_start_in) begin
            r_cnt   <= '0;
            r_k_sq  <= c_cnt_w'(fu_kernel_size_in) * c_cnt_w'(fu_kernel_size_in);
            r_shift <= fu_shift_in;
            r_bias  <= fu_bias_in;
            r_err   <= 1'b0;
            for (int i = 0; i < c_elems; i++) r_weight[i] <= '0;
        end else begin
            if ((r_state == LOAD) && fu_weight_valid_in) begin
                r_weight[r_cnt] <= fu_weight_in;
                r_cnt           <= r_cnt + c_cnt_w'(1);
            end
            if (w_err_set) begin
                r_err <= 1'b1;
            end
        end
    end

    // Row-wise partial sums; unused kernel slots hold zero weights.
    always_comb begin
        for (int r = 0; r < MAX_KERNEL_SIZE; r++) begin
            w_part[r] = '0;
            for (int c = 0; c < MAX_KERNEL_SIZE; c++) begin
                w_part[r] = w_part[r] + ACC_WIDTH'(r_prod[r*MAX_KERNEL_SIZE + c]);
            end
        end
        w_sum = r_bias2;
        for (int r = 0; r < MAX_KERNEL_SIZE; r++) begin
            w_sum = w_sum + r_part[r];
        end
    end

    // Bias and shift travel with each window so a reload never disturbs it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vld    <= '0;
            r_bias1  <= '0;
            r_bias2  <= '0;
            r_acc3   <= '0;
            r_acc4   <= '0;
            r_shift1 <= '0;
            r_shift2 <= '0;
            r_shift3 <= '0;
            r_result <= '0;
            for (int i = 0; i < c_elems; i++) r_prod[i] <= '0;
            for (int r = 0; r < MAX_KERNEL_SIZE; r++) r_part[r] <= '0;
        end else begin
            r_vld <= {r_vld[2:0], w_accept};
            if (w_accept) begin
                for (int i = 0; i < c_elems; i++) begin
                    r_prod[i] <= c_prod_w'(signed'({1'b0, fu_window_in[i]})) *
                                 c_prod_w'(r_weight[i]);
                end
                r_bias1  <= r_bias;
                r_shift1 <= r_shift;
            end
            if (r_vld[0]) begin
                for (int r = 0; r < MAX_KERNEL_SIZE; r++) r_part[r] <= w_part[r];
                r_bias2  <= r_bias1;
                r_shift2 <= r_shift1;
            end
            if (r_vld[1]) begin
                r_acc3   <= w_sum;
                r_shift3 <= r_shift2;
            end
            if (r_vld[2]) begin
                r_acc4   <= r_acc3;
                r_result <= w_result;
            end
        end
    end

    requant_clamp #(
        .DATA_WIDTH  (DATA_WIDTH),
        .SHIFT_WIDTH (SHIFT_WIDTH)
    ) u_requant (
        .i_acc    (r_acc3),
        .i_shift  (r_shift3),
        .o_result (w_result)
    );

    assign fu_weights_ready_out = w_ready;
    assign fu_result_valid_out  = r_vld[3];
    assign fu_result_out        = r_result;
    assign fu_acc_out           = r_acc4;
    assign fu_err_out           = r_err;

endmodule
`default_nettype wire

// File: tb/tb_conv_mac_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_conv_mac_unit
//  Description : Randomised bench for conv_mac_unit against a behavioural model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_conv_mac_unit;

    localparam int NE = 49;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [2:0]  fu_kernel_size_in;
    logic [4:0]  fu_shift_in;
    logic [23:0] fu_bias_in;
    logic        fu_load_start_in;
    logic [7:0]  fu_weight_in;
    logic        fu_weight_valid_in;
    logic        fu_weights_ready_out;
    logic [7:0]  fu_window_in [0:NE-1];
    logic        fu_window_valid_in;
    logic [7:0]  fu_result_out;
    logic [23:0] fu_acc_out;
    logic        fu_result_valid_out;
    logic        fu_err_out;

    conv_mac_unit dut (
        .clk                  (clk),
        .rst_n                (rst_n),
        .fu_kernel_size_in    (fu_kernel_size_in),
        .fu_shift_in          (fu_shift_in),
        .fu_bias_in           (fu_bias_in),
        .fu_load_start_in     (fu_load_start_in),
        .fu_weight_in         (fu_weight_in),
        .fu_weight_valid_in   (fu_weight_valid_in),
        .fu_weights_ready_out (fu_weights_ready_out),
        .fu_window_in         (fu_window_in),
        .fu_window_valid_in   (fu_window_valid_in),
        .fu_result_out        (fu_result_out),
        .fu_acc_out           (fu_acc_out),
        .fu_result_valid_out  (fu_result_valid_out),
        .fu_err_out           (fu_err_out)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int edge_cnt = 0;
    bit chk_en = 1'b0;

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    typedef struct {
        int     due;
        longint acc;
        int     res;
    } exp_t;

    exp_t   q[$];
    exp_t   cur;
    int     m_w [NE];
    int     m_k, m_shift, m_cnt;
    longint m_bias;
    bit     m_load, m_ready, m_err;
    longint last_acc;
    int     last_res;
    int     kw [NE];
    int     pix [NE];

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int requant(input longint acc, input int sh);
        longint r;
        if (sh > 0) r = (acc + (longint'(1) <<< (sh - 1))) >>> sh;
        else        r = acc;
        if (r < 0)   return 0;
        if (r > 255) return 255;
        return int'(r);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NE; i++) m_w[i] = 0;
        m_k = 0; m_shift = 0; m_cnt = 0; m_bias = 0;
        m_load = 0; m_ready = 0; m_err = 0;
        q.delete();
        last_acc = 0; last_res = 0;
    endtask

    // Applies the current input values as the next rising edge will see them.
    task automatic model_step();
        exp_t   e;
        longint acc;
        if (!rst_n) begin
            model_reset();
            return;
        end
        if (fu_window_valid_in) begin
            if (m_ready) begin
                acc = m_bias;
                for (int i = 0; i < NE; i++) acc += longint'(fu_window_in[i]) * m_w[i];
                e.due = edge_cnt + 4;
                e.acc = acc;
                e.res = requant(acc, m_shift);
                q.push_back(e);
            end else begin
                m_err = 1;
            end
        end
        if (fu_load_start_in) begin
            for (int i = 0; i < NE; i++) m_w[i] = 0;
            m_cnt   = 0;
            m_k     = int'(fu_kernel_size_in);
            m_shift = int'(fu_shift_in);
            m_bias  = longint'($signed(fu_bias_in));
            m_err   = 0;
            m_ready = (m_k == 0);
            m_load  = (m_k != 0);
        end else if (m_load && fu_weight_valid_in) begin
            m_w[m_cnt] = int'($signed(fu_weight_in));
            m_cnt++;
            if (m_cnt == m_k * m_k) begin
                m_load  = 0;
                m_ready = 1;
            end
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            if (q.size() > 0 && q[0].due == edge_cnt) begin
                cur = q.pop_front();
                check("valid", fu_result_valid_out, 1);
                check("acc", longint'($signed(fu_acc_out)), cur.acc);
                check("result", fu_result_out, cur.res);
                last_acc = cur.acc;
                last_res = cur.res;
            end else begin
                check("valid_idle", fu_result_valid_out, 0);
                check("acc_hold", longint'($signed(fu_acc_out)), last_acc);
                check("result_hold", fu_result_out, last_res);
            end
            check("ready", fu_weights_ready_out, m_ready);
            check("err", fu_err_out, m_err);
        end
    end

    task automatic tick();
        model_step();
        @(negedge clk);
        #1;
    endtask

    task automatic load_kernel(input int k, input int sh, input int b, input bit gaps);
        fu_load_start_in  = 1'b1;
        fu_kernel_size_in = 3'(k);
        fu_shift_in       = 5'(sh);
        fu_bias_in        = 24'(b);
        tick();
        fu_load_start_in  = 1'b0;
        for (int i = 0; i < k * k; i++) begin
            if (gaps) repeat ($urandom_range(0, 2)) tick();
            fu_weight_valid_in = 1'b1;
            fu_weight_in       = 8'(kw[i]);
            tick();
            fu_weight_valid_in = 1'b0;
        end
    endtask

    task automatic send_window();
        for (int i = 0; i < NE; i++) fu_window_in[i] = 8'(pix[i]);
        fu_window_valid_in = 1'b1;
        tick();
        fu_window_valid_in = 1'b0;
    endtask

    task automatic rand_kernel(input int k);
        for (int i = 0; i < NE; i++) kw[i] = (i < k * k) ? int'($urandom_range(0, 255)) - 128 : 0;
    endtask

    task automatic rand_pix(input int k);
        for (int i = 0; i < NE; i++) pix[i] = (i < k * k) ? int'($urandom_range(0, 255)) : 0;
    endtask

    function automatic int rand_bias();
        return int'($urandom_range(0, 2097151)) - 1048576;
    endfunction

    task automatic expect_out(input string tag, input longint acc, input int res);
        check({tag, "_valid"}, fu_result_valid_out, 1);
        check({tag, "_acc"}, longint'($signed(fu_acc_out)), acc);
        check({tag, "_result"}, fu_result_out, res);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: run exceeded %0d time units", 1_000_000);
        $fatal(1, "watchdog expired");
    end

    initial begin
        fu_kernel_size_in  = '0;
        fu_shift_in        = '0;
        fu_bias_in         = '0;
        fu_load_start_in   = 1'b0;
        fu_weight_in       = '0;
        fu_weight_valid_in = 1'b0;
        fu_window_valid_in = 1'b0;
        for (int i = 0; i < NE; i++) fu_window_in[i] = '0;
        model_reset();
        repeat (2) begin @(negedge clk); #1; end
        check("rst_ready", fu_weights_ready_out, 0);
        check("rst_valid", fu_result_valid_out, 0);
        check("rst_result", fu_result_out, 0);
        check("rst_acc", fu_acc_out, 0);
        check("rst_err", fu_err_out, 0);
        rst_n  = 1'b1;
        chk_en = 1'b1;
        tick();

        // 3x3 all-ones, window 1..9
        for (int i = 0; i < NE; i++) kw[i] = (i < 9) ? 1 : 0;
        load_kernel(3, 0, 0, 1'b0);
        check("t1_ready", fu_weights_ready_out, 1);
        for (int i = 0; i < NE; i++) pix[i] = (i < 9) ? i + 1 : 0;
        send_window();
        tick();
        tick();
        check("t1_latency_early", fu_result_valid_out, 0);
        tick();
        expect_out("t1", 45, 45);

        // 3x3 all -1, window of 10s
        for (int i = 0; i < NE; i++) kw[i] = (i < 9) ? -1 : 0;
        load_kernel(3, 0, 0, 1'b1);
        for (int i = 0; i < NE; i++) pix[i] = (i < 9) ? 10 : 0;
        send_window();
        repeat (3) tick();
        expect_out("t2", -90, 0);

        // 7x7 of 127, all-255 window, shift 13 then shift 0
        for (int i = 0; i < NE; i++) kw[i] = 127;
        for (int i = 0; i < NE; i++) pix[i] = 255;
        load_kernel(7, 13, 0, 1'b0);
        send_window();
        repeat (3) tick();
        expect_out("t3a", 1586865, 194);
        load_kernel(7, 0, 0, 1'b0);
        send_window();
        repeat (3) tick();
        expect_out("t3b", 1586865, 255);

        // 10 windows with one bubble after the fifth
        rand_kernel(3);
        load_kernel(3, $urandom_range(0, 10), rand_bias(), 1'b1);
        for (int n = 0; n < 10; n++) begin
            rand_pix(3);
            send_window();
            if (n == 4) tick();
        end
        repeat (6) tick();

        // window during LOAD sets the sticky error; a new start clears it
        rand_kernel(3);
        fu_load_start_in  = 1'b1;
        fu_kernel_size_in = 3'd3;
        fu_shift_in       = 5'd2;
        fu_bias_in        = 24'd0;
        tick();
        fu_load_start_in  = 1'b0;
        for (int i = 0; i < 2; i++) begin
            fu_weight_valid_in = 1'b1;
            fu_weight_in       = 8'(kw[i]);
            tick();
        end
        fu_weight_valid_in = 1'b0;
        rand_pix(3);
        send_window();
        check("t5_err_set", fu_err_out, 1);
        check("t5_not_ready", fu_weights_ready_out, 0);
        repeat (5) tick();
        load_kernel(3, 2, 0, 1'b0);
        check("t5_err_clear", fu_err_out, 0);

        // reload with three windows in flight
        rand_kernel(3);
        load_kernel(3, 4, rand_bias(), 1'b0);
        for (int n = 0; n < 3; n++) begin
            rand_pix(3);
            send_window();
        end
        rand_kernel(2);
        load_kernel(2, 1, rand_bias(), 1'b0);
        for (int n = 0; n < 3; n++) begin
            rand_pix(2);
            send_window();
        end
        repeat (6) tick();

        // zero-size kernel: result is the clamped bias
        load_kernel(0, 0, 100, 1'b0);
        check("t7_ready", fu_weights_ready_out, 1);
        for (int i = 0; i < NE; i++) pix[i] = 0;
        send_window();
        repeat (3) tick();
        expect_out("t7", 100, 100);

        // random soak
        for (int n = 0; n < 500; n++) begin
            if ($urandom_range(0, 60) == 0) begin
                rand_kernel(7);
                for (int i = 0; i < NE; i++) kw[i] = kw[i];
                fu_load_start_in  = 1'b1;
                fu_kernel_size_in = 3'($urandom_range(0, 7));
                fu_shift_in       = 5'(($urandom_range(0, 3) == 0) ? $urandom_range(0, 31)
                                                                   : $urandom_range(0, 12));
                fu_bias_in        = 24'(rand_bias());
            end else begin
                fu_weight_valid_in = ($urandom_range(0, 3) != 0);
                fu_weight_in       = 8'($urandom_range(0, 255));
                rand_pix(m_k);
                for (int i = 0; i < NE; i++) fu_window_in[i] = 8'(pix[i]);
                fu_window_valid_in = ($urandom_range(0, 1) == 1);
            end
            tick();
            fu_load_start_in   = 1'b0;
            fu_weight_valid_in = 1'b0;
            fu_window_valid_in = 1'b0;
        end
        repeat (6) tick();

        // asynchronous reset with results in flight
        rand_kernel(3);
        load_kernel(3, 3, rand_bias(), 1'b0);
        for (int n = 0; n < 6; n++) begin
            rand_pix(3);
            send_window();
        end
        rst_n = 1'b0;
        #1;
        check("rst_mid_valid", fu_result_valid_out, 0);
        check("rst_mid_result", fu_result_out, 0);
        check("rst_mid_acc", fu_acc_out, 0);
        check("rst_mid_ready", fu_weights_ready_out, 0);
        check("rst_mid_err", fu_err_out, 0);
        model_reset();
        repeat (3) tick();
        rst_n = 1'b1;
        repeat (6) tick();

        for (int i = 0; i < NE; i++) kw[i] = (i < 4) ? 2 : 0;
        load_kernel(2, 1, 7, 1'b0);
        for (int i = 0; i < NE; i++) pix[i] = (i < 4) ? 20 : 0;
        send_window();
        repeat (3) tick();
        expect_out("t9", 167, 84);
        repeat (2) tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
